pnp_table_apb: RTL and testbench

Parametrised Plug'n'Play descriptor table with change detection, serving firmware over APB. It continuously scans a vector of up to 32 device descriptors driven by SoC devices. It keeps a shadow copy of each slot and flags slots whose descriptor changed since last acknowledged, for hot-reconfigurable subsystems such as PCIe DMA and DDR. It sits on the APB bridge and replaces the fixed-size PnP register block.

---
 rtl/pnp_table_apb.sv | 172 +++++++++++++++++
 tb/tb_pnp_table_apb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pnp_table_apb.sv
// Plug'n'Play descriptor table: scans live SoC descriptors one slot per cycle,
// keeps a shadow copy, flags changed slots and serves everything over APB
// with one wait state.
module pnp_table_apb #(
    parameter int         SLOTS   = 16,
    parameter logic [7:0] VERSION = 8'h02
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [SLOTS*170-1:0] i_cfg,
    input  logic                 i_apb_psel,
    input  logic                 i_apb_penable,
    input  logic                 i_apb_pwrite,
    input  logic [11:0]          i_apb_paddr,
    input  logic [31:0]          i_apb_pwdata,
    output logic [31:0]          o_apb_prdata,
    output logic                 o_apb_pready,
    output logic                 o_apb_pslverr,
    output logic                 o_irq
);

    localparam int            DW   = 170;
    localparam int            IW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [IW-1:0] LAST = IW'(SLOTS - 1);

    // Descriptor layout, MSB to LSB: size[7:0], type[1:0], addr_start[63:0],
    // addr_end[63:0], vid[15:0], did[15:0].
    logic [DW-1:0] live [SLOTS];

    for (genvar n = 0; n < SLOTS; n++) begin : g_unpack
        assign live[n] = i_cfg[n*DW +: DW];
    end

    logic [DW-1:0]    shadow_q [SLOTS];
    logic [DW-1:0]    shadow_d [SLOTS];
    logic [SLOTS-1:0] changed_q, changed_d;
    logic [SLOTS-1:0] mask_q, mask_d;
    logic             enable_q, enable_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [31:0]      scan_cnt_q, scan_cnt_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             pready_q, pready_d;
    logic             pslverr_q, pslverr_d;
    logic             irq_q, irq_d;

    logic [SLOTS-1:0] set_bits;
    logic [31:0]      rdata;
    logic             slverr;
    logic             access;
    logic [4:0]       rd_slot;
    logic [2:0]       rd_word;
    logic [IW-1:0]    rd_idx;
    logic [DW-1:0]    rd_desc;

    // Byte-lane bits and unused write-data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{i_apb_paddr[1:0], i_apb_pwdata};

    // Only the first access-phase cycle acts; the pready cycle is a no-op.
    assign access = i_apb_psel & i_apb_penable & ~pready_q;

    // Scanner: compare one slot per cycle, capture and flag on mismatch.
    always_comb begin
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        scan_cnt_d = scan_cnt_q;
        set_bits   = '0;
        if (enable_q) begin
            if (live[idx_q] != shadow_q[idx_q]) begin
                shadow_d[idx_q] = live[idx_q];
                set_bits[idx_q] = 1'b1;
            end
            if (idx_q == LAST) begin
                idx_d      = '0;
                scan_cnt_d = scan_cnt_q + 32'd1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Read decode: register block, descriptor window, error region.
    always_comb begin
        rd_slot = i_apb_paddr[9:5];
        rd_word = i_apb_paddr[4:2];
        rd_idx  = rd_slot[IW-1:0];
        rd_desc = shadow_q[rd_idx];
        rdata   = '0;
        slverr  = 1'b0;
        if (i_apb_paddr[11]) begin
            slverr = 1'b1;
        end else if (i_apb_paddr[10]) begin
            if (int'(rd_slot) < SLOTS) begin
                case (rd_word)
                    3'd0:    rdata = {rd_desc[15:0], rd_desc[31:16]};
                    3'd1:    rdata = {22'b0, rd_desc[161:160], rd_desc[169:162]};
                    3'd2:    rdata = rd_desc[127:96];
                    3'd3:    rdata = rd_desc[159:128];
                    3'd4:    rdata = rd_desc[63:32];
                    3'd5:    rdata = rd_desc[95:64];
                    default: rdata = '0;
                endcase
            end
        end else begin
            case (i_apb_paddr[9:2])
                8'd0:    rdata = {16'h00F2, VERSION, 8'(SLOTS)};
                8'd1:    rdata = 32'(changed_q);
                8'd2:    rdata = 32'(mask_q);
                8'd3:    rdata = {19'b0, 5'(idx_q), 7'b0, enable_q};
                8'd4:    rdata = scan_cnt_q;
                default: rdata = '0;
            endcase
        end
    end

    // APB response, register writes and interrupt; scanner set wins over W1C.
    always_comb begin
        changed_d = changed_q | set_bits;
        mask_d    = mask_q;
        enable_d  = enable_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        pready_d  = 1'b0;
        if (access) begin
            prdata_d  = rdata;
            pslverr_d = slverr;
            pready_d  = 1'b1;
            if (i_apb_pwrite && (i_apb_paddr[11:10] == 2'b00)) begin
                case (i_apb_paddr[9:2])
                    8'd1:    changed_d = (changed_q & ~i_apb_pwdata[SLOTS-1:0]) | set_bits;
                    8'd2:    mask_d    = i_apb_pwdata[SLOTS-1:0];
                    8'd3:    enable_d  = i_apb_pwdata[0];
                    default: ;
                endcase
            end
        end
        irq_d = |(changed_q & mask_q);
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            for (int n = 0; n < SLOTS; n++) shadow_q[n] <= '0;
            changed_q  <= '0;
            mask_q     <= '0;
            enable_q   <= 1'b1;
            idx_q      <= '0;
            scan_cnt_q <= '0;
            prdata_q   <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            changed_q  <= changed_d;
            mask_q     <= mask_d;
            enable_q   <= enable_d;
            idx_q      <= idx_d;
            scan_cnt_q <= scan_cnt_d;
            prdata_q   <= prdata_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            irq_q      <= irq_d;
        end
    end

    assign o_apb_prdata  = prdata_q;
    assign o_apb_pready  = pready_q;
    assign o_apb_pslverr = pslverr_q;
    assign o_irq         = irq_q;

endmodule

// File: tb/tb_pnp_table_apb.sv
// Bench for pnp_table_apb: directed scenarios plus randomized traffic,
// checked against a descriptor-level reference model.
module tb_pnp_table_apb;

    localparam int SLOTS = 16;

    typedef struct packed {
        logic [7:0]  size;
        logic [1:0]  dtype;
        logic [63:0] astart;
        logic [63:0] aend;
        logic [15:0] vid;
        logic [15:0] did;
    } desc_t;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic [SLOTS*170-1:0] cfg;
    logic                 psel, penable, pwrite;
    logic [11:0]          paddr;
    logic [31:0]          pwdata;
    logic [31:0]          prdata;
    logic                 pready, pslverr, irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    desc_t       m_live   [SLOTS];
    desc_t       m_shadow [SLOTS];
    logic [15:0] m_changed, m_mask;
    bit          m_en, m_irq, m_acc;
    int          m_idx;
    logic [31:0] m_cnt;

    pnp_table_apb #(.SLOTS(SLOTS), .VERSION(8'h02)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_cfg(cfg),
        .i_apb_psel(psel), .i_apb_penable(penable), .i_apb_pwrite(pwrite),
        .i_apb_paddr(paddr), .i_apb_pwdata(pwdata),
        .o_apb_prdata(prdata), .o_apb_pready(pready), .o_apb_pslverr(pslverr),
        .o_irq(irq)
    );

    always #5 clk = ~clk;

    always_comb begin
        cfg = '0;
        for (int n = 0; n < SLOTS; n++) cfg[n*170 +: 170] = m_live[n];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using the inputs present at the edge.
    function automatic void model_step();
        logic [15:0] set_v, clr_v, mask_n;
        bit          en_n, irq_n;
        if (!nrst) begin
            for (int n = 0; n < SLOTS; n++) m_shadow[n] = '0;
            m_changed = '0; m_mask = '0; m_en = 1; m_idx = 0; m_cnt = '0; m_irq = 0;
            return;
        end
        irq_n  = |(m_changed & m_mask);
        set_v  = '0;
        clr_v  = '0;
        mask_n = m_mask;
        en_n   = m_en;
        if (m_acc && pwrite && paddr < 12'h400) begin
            case (int'(paddr >> 2))
                1: clr_v  = pwdata[15:0];
                2: mask_n = pwdata[15:0];
                3: en_n   = pwdata[0];
                default: ;
            endcase
        end
        if (m_en) begin
            if (m_live[m_idx] != m_shadow[m_idx]) begin
                m_shadow[m_idx] = m_live[m_idx];
                set_v[m_idx]    = 1'b1;
            end
            m_idx = (m_idx + 1) % SLOTS;
            if (m_idx == 0) m_cnt = m_cnt + 1;
        end
        m_changed = (m_changed & ~clr_v) | set_v;
        m_mask    = mask_n;
        m_en      = en_n;
        m_irq     = irq_n;
    endfunction

    function automatic void m_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        int    slot, off;
        desc_t s;
        d = '0;
        e = 1'b0;
        if (a >= 12'h800) begin
            e = 1'b1;
        end else if (a >= 12'h400) begin
            slot = (int'(a) - 'h400) / 32;
            off  = (int'(a) % 32) / 4;
            if (slot < SLOTS) begin
                s = m_shadow[slot];
                case (off)
                    0: d = {s.did, s.vid};
                    1: d = {22'b0, s.dtype, s.size};
                    2: d = s.astart[31:0];
                    3: d = s.astart[63:32];
                    4: d = s.aend[31:0];
                    5: d = s.aend[63:32];
                    default: d = '0;
                endcase
            end
        end else begin
            case (int'(a) / 4)
                0: d = {16'h00F2, 8'h02, 8'(SLOTS)};
                1: d = 32'(m_changed);
                2: d = 32'(m_mask);
                3: d = 32'((m_idx << 8) | int'(m_en));
                4: d = m_cnt;
                default: d = '0;
            endcase
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                       input string tag, output logic [31:0] rd);
        logic [31:0] exp_d;
        logic        exp_e;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd;
        tick();
        penable = 1;
        m_read(a, exp_d, exp_e);
        m_acc = 1;
        tick();
        m_acc = 0;
        rd = prdata;
        check({tag, "_rdy"}, 32'(pready), 32'd1);
        check({tag, "_err"}, 32'(pslverr), 32'(exp_e));
        if (!wr) check(tag, prdata, exp_d);
        tick();
        check({tag, "_rdy_drop"}, 32'(pready), 32'd0);
        psel = 0; penable = 0;
    endtask

    task automatic rd(input logic [11:0] a, input string tag, output logic [31:0] r);
        apb(1'b0, a, $urandom, tag, r);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input string tag);
        logic [31:0] r;
        apb(1'b1, a, d, tag, r);
    endtask

    function automatic desc_t rand_desc();
        desc_t d;
        d.size   = 8'($urandom);
        d.dtype  = 2'($urandom);
        d.astart = {$urandom, $urandom};
        d.aend   = {$urandom, $urandom};
        d.vid    = 16'($urandom);
        d.did    = 16'($urandom);
        if ($urandom_range(0, 3) == 0) d = '0;
        return d;
    endfunction

    function automatic logic [11:0] rand_addr();
        logic [11:0] a;
        case ($urandom_range(0, 3))
            0:       a = 12'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            1:       a = 12'('h400 + $urandom_range(0, 19) * 32 + $urandom_range(0, 7) * 4);
            2:       a = 12'('h800 + $urandom_range(0, 2047));
            default: a = 12'($urandom);
        endcase
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] wd;
        desc_t       d;
        nrst = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; m_acc = 0;
        for (int n = 0; n < SLOTS; n++) m_live[n] = '0;
        m_changed = '0; m_mask = '0; m_en = 1; m_idx = 0; m_cnt = '0; m_irq = 0;
        for (int n = 0; n < SLOTS; n++) m_shadow[n] = '0;

        // Reset state
        repeat (3) tick();
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        nrst = 1;
        tick();
        rd(12'h000, "id", r);        check("id_const", r, 32'h00F20210);
        rd(12'h004, "changed0", r);  check("changed0_const", r, 32'd0);
        rd(12'h008, "mask0", r);     check("mask0_const", r, 32'd0);
        rd(12'h00C, "scanctrl0", r); check("scanctrl0_en", r & 32'h1, 32'h1);

        // Discovery of slot 3
        d = '0; d.vid = 16'h00F2; d.did = 16'h0076;
        d.astart = 64'h10060000; d.aend = 64'h10061000;
        m_live[3] = d;
        repeat (SLOTS + 1) tick();
        rd(12'h004, "chg3", r);   check("chg3_const", r, 32'h8);
        rd(12'h460, "s3_w0", r);  check("s3_w0_const", r, 32'h007600F2);
        rd(12'h468, "s3_as", r);  check("s3_as_const", r, 32'h10060000);
        rd(12'h470, "s3_ae", r);  check("s3_ae_const", r, 32'h10061000);
        rd(12'h464, "s3_w1", r);
        rd(12'h46C, "s3_ash", r);
        repeat (SLOTS) tick();
        rd(12'h010, "scan_cnt", r); check("scan_cnt_ge1", 32'(r >= 1), 32'd1);

        // Interrupt on masked change, cleared by W1C
        wr(12'h008, 32'h8, "mask_w");
        wr(12'h004, 32'hFFFF_FFFF, "clr_all");
        m_live[3].did = 16'h0077;
        repeat (SLOTS + 2) tick();
        check("irq_set", 32'(irq), 32'd1);
        wr(12'h004, 32'h8, "w1c3");
        check("irq_clr", 32'(irq), 32'd0);

        // Scanner set and W1C on slot 5 in the same cycle
        for (int k = 0; k < 3 * SLOTS && m_idx != 7; k++) tick();
        m_live[5].vid = m_shadow[5].vid ^ 16'h1;
        for (int k = 0; k < 3 * SLOTS && m_idx != 4; k++) tick();
        wr(12'h004, 32'h20, "w1c5_collide");
        rd(12'h004, "chg5", r); check("chg5_set_wins", (r >> 5) & 32'h1, 32'h1);

        // Frozen scanner holds idx and shadow
        wr(12'h004, 32'hFFFF, "clr_all2");
        wr(12'h00C, 32'h0, "scan_off");
        m_live[2] = rand_desc();
        m_live[2].did = m_shadow[2].did ^ 16'h00FF;
        repeat (100) tick();
        rd(12'h004, "chg_frozen", r);  check("chg2_frozen", (r >> 2) & 32'h1, 32'h0);
        rd(12'h00C, "idx_frozen", r);
        rd(12'h440, "s2_frozen", r);
        wr(12'h00C, 32'h1, "scan_on");
        repeat (SLOTS + 1) tick();
        rd(12'h004, "chg2", r);        check("chg2_flag", (r >> 2) & 32'h1, 32'h1);

        // Error region and absent slot
        rd(12'h900, "err900", r);      check("err900_data", r, 32'd0);
        rd(12'h680, "slot20", r);      check("slot20_data", r, 32'd0);
        wr(12'h900, 32'hFFFF, "err_wr");

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 6))
                0:       m_live[$urandom_range(0, SLOTS - 1)] = rand_desc();
                1, 2:    rd(rand_addr(), "rnd_rd", r);
                3:       wr(12'h004, $urandom, "rnd_w1c");
                4:       wr(12'h008, $urandom, "rnd_mask");
                5: begin
                    wd = $urandom;
                    wd[0] = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 1) == 1) wr(12'h00C, wd, "rnd_ctrl");
                    else wr(rand_addr(), wd, "rnd_wr");
                end
                default: repeat ($urandom_range(1, 20)) tick();
            endcase
        end
        wr(12'h00C, 32'h1, "scan_on2");
        rd(12'h004, "rnd_chg_end", r);

        // Reset in the middle of an APB access, then rediscovery
        psel = 1; penable = 0; pwrite = 0; paddr = 12'h004;
        tick();
        penable = 1; nrst = 0;
        tick();
        check("mid_rst_pready", 32'(pready), 32'd0);
        check("mid_rst_prdata", prdata, 32'd0);
        psel = 0; penable = 0; nrst = 1;
        tick();
        repeat (SLOTS + 1) tick();
        rd(12'h004, "rediscover", r);
        rd(12'h010, "cnt_after_rst", r);
        rd(12'h008, "mask_after_rst", r); check("mask_after_rst_const", r, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
